// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared types and constants for the LED pattern generator.
//   led_mode_t : per-channel drive mode (OFF, ON, BLINK, PWM)
//   MODE_W     : width of the mode field on the config port
//   RST_MODE   : mode every channel takes out of reset
//   ch_w()     : width of a channel index, never less than one bit
// -----------------------------------------------------------------------------
package led_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      LED_OFF   = 2'd0,
      LED_ON    = 2'd1,
      LED_BLINK = 2'd2,
      LED_PWM   = 2'd3
   } led_mode_t;

   localparam led_mode_t RST_MODE = LED_OFF;

   // A single-channel build still needs a 1-bit select port.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : led_pkg

// File: rtl/led_channel.sv
// -----------------------------------------------------------------------------
// led_channel
// One LED channel: holds its configuration (mode, period, duty), a free
// running period counter with blink phase, and the registered LED and wrap
// outputs.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_i        : write strobe for this channel (already qualified)
//   mode_i      : mode to store on a write
//   period_i    : BLINK half-period minus one to store on a write
//   duty_i      : PWM high count to store on a write
//   pwm_cnt_i   : shared PWM frame counter
//   led_o       : registered LED drive, active-high
//   wrap_o      : one-cycle pulse after the period counter wraps
// -----------------------------------------------------------------------------
module led_channel
   import led_pkg::*;
#(
   parameter int unsigned CNT_W      = 27,
   parameter int unsigned PWM_W      = 8,
   parameter int unsigned DEF_PERIOD = 20000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_i,
   input  led_mode_t        mode_i,
   input  logic [CNT_W-1:0] period_i,
   input  logic [PWM_W-1:0] duty_i,
   input  logic [PWM_W-1:0] pwm_cnt_i,
   output logic             led_o,
   output logic             wrap_o
);

   led_mode_t        mode_q,   mode_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [PWM_W-1:0] duty_q,   duty_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             phase_q,  phase_d;
   logic             led_q,    led_d;
   logic             wrap_q,   wrap_d;
   logic             hit;

   always_comb begin
      mode_d   = mode_q;
      period_d = period_q;
      duty_d   = duty_q;

      // The counter runs in every mode so wrap keeps pulsing regardless.
      hit      = (cnt_q == period_q);
      cnt_d    = hit ? '0 : cnt_q + CNT_W'(1);
      phase_d  = phase_q ^ hit;
      wrap_d   = hit;

      // LED follows the stored mode, so a new mode shows one edge later.
      unique case (mode_q)
         LED_OFF:   led_d = 1'b0;
         LED_ON:    led_d = 1'b1;
         LED_BLINK: led_d = phase_q;
         LED_PWM:   led_d = (pwm_cnt_i < duty_q);
         default:   led_d = 1'b0;
      endcase

      // A write restarts the channel and overrides a wrap in the same edge.
      if (wr_i) begin
         mode_d   = mode_i;
         period_d = period_i;
         duty_d   = duty_i;
         cnt_d    = '0;
         phase_d  = 1'b0;
         wrap_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q   <= RST_MODE;
         period_q <= CNT_W'(DEF_PERIOD);
         duty_q   <= '0;
         cnt_q    <= '0;
         phase_q  <= 1'b0;
         led_q    <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         period_q <= period_d;
         duty_q   <= duty_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         led_q    <= led_d;
         wrap_q   <= wrap_d;
      end
   end

   assign led_o  = led_q;
   assign wrap_o = wrap_q;

endmodule : led_channel

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
// Multi-channel LED pattern generator. Each channel is OFF, ON, BLINK with a
// programmable half-period, or PWM-dimmed with a programmable duty. Channels
// are reconfigured at runtime through a valid/ready write port.
//   clk, rst_n  : clock, asynchronous active-low reset
//   cfg_valid   : config write request
//   cfg_ready   : config write can be accepted (low only during reset)
//   cfg_ch      : target channel; out-of-range writes are accepted and dropped
//   cfg_mode    : 0 OFF, 1 ON, 2 BLINK, 3 PWM
//   cfg_period  : BLINK half-period minus one
//   cfg_duty    : PWM high count per 2^PWM_W frame
//   led         : registered LED drive per channel, active-high
//   wrap        : one-cycle pulse per channel on period counter wrap
// -----------------------------------------------------------------------------
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int unsigned N_CH       = 3,
   parameter int unsigned CNT_W      = 27,
   parameter int unsigned PWM_W      = 8,
   parameter int unsigned DEF_PERIOD = 20000000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [ch_w(N_CH)-1:0]    cfg_ch,
   input  logic [MODE_W-1:0]        cfg_mode,
   input  logic [CNT_W-1:0]         cfg_period,
   input  logic [PWM_W-1:0]         cfg_duty,
   output logic [N_CH-1:0]          led,
   output logic [N_CH-1:0]          wrap
);

   localparam int CH_W = ch_w(N_CH);

   logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic             accept;
   logic [N_CH-1:0]  wr;

   // Nothing stalls a write; the port is only closed while held in reset.
   assign cfg_ready = rst_n;
   assign accept    = cfg_valid && cfg_ready;

   // Shared PWM frame counter; free running, never touched by writes.
   assign pwm_cnt_d = pwm_cnt_q + PWM_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pwm_cnt_q <= '0;
      else        pwm_cnt_q <= pwm_cnt_d;
   end

   // An index with no matching channel raises no strobe, so it is dropped.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign wr[i] = accept && (cfg_ch == CH_W'(i));

      led_channel #(
         .CNT_W      (CNT_W),
         .PWM_W      (PWM_W),
         .DEF_PERIOD (DEF_PERIOD)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .wr_i      (wr[i]),
         .mode_i    (led_mode_t'(cfg_mode)),
         .period_i  (cfg_period),
         .duty_i    (cfg_duty),
         .pwm_cnt_i (pwm_cnt_q),
         .led_o     (led[i]),
         .wrap_o    (wrap[i])
      );
   end

endmodule : led_pattern_gen

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;
   import led_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_ch;
   logic [1:0]  cfg_mode;
   logic [26:0] cfg_period;
   logic [7:0]  cfg_duty;
   logic [2:0]  led;
   logic [2:0]  wrap;

   led_pattern_gen #(
      .N_CH(3), .CNT_W(27), .PWM_W(8), .DEF_PERIOD(20000000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
      .cfg_duty(cfg_duty), .led(led), .wrap(wrap)
   );

   always #5 clk = ~clk;

   // Edge counter: after posedge n, cyc == n.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         at;
      logic [2:0] lm, le, wm, we;
      logic       re;
   } item_t;

   item_t sb_q[$];
   string nm_q[$];

   int  n_cmp = 0;
   int  n_err = 0;
   bit  done = 1'b0;
   int  done_cyc = 0;
   int  k0 = 1 << 30;   // edge of last ch0 BLINK(period 3) write
   int  k2 = 1 << 30;   // edge of ch2 BLINK(period 0) write
   int  pr = 0;         // edge at which reset was released

   // Expected values derived from the documented timing.
   function automatic logic b0l(input int t);
      return (t > k0) && ((((t - k0 - 1) / 4) % 2) == 1);
   endfunction
   function automatic logic b0w(input int t);
      return (t > k0) && (((t - k0) % 4) == 0);
   endfunction
   function automatic logic b2l(input int t);
      return (t > k2) && (((t - k2 - 1) % 2) == 1);
   endfunction
   function automatic logic b2w(input int t);
      return (t > k2);
   endfunction
   function automatic logic p1(input int t, input int duty);
      return ((t - 1 - pr) % 256) < duty;
   endfunction

   task automatic push(input int at, input logic [2:0] lm, input logic [2:0] le,
                       input logic [2:0] wm, input logic [2:0] we, input logic re,
                       input string nm);
      item_t x;
      x.at = at; x.lm = lm; x.le = le; x.wm = wm; x.we = we; x.re = re;
      sb_q.push_back(x);
      nm_q.push_back(nm);
   endtask

   task automatic pushf(input int at, input logic [2:0] le, input logic [2:0] we,
                        input logic re, input string nm);
      push(at, 3'b111, le, 3'b111, we, re, nm);
   endtask

   task automatic wr(input int ch, input logic [1:0] md, input int per, input int dt);
      cfg_ch     = 2'(ch);
      cfg_mode   = md;
      cfg_period = 27'(per);
      cfg_duty   = 8'(dt);
      cfg_valid  = 1'b1;
      @(posedge clk); #1;
      cfg_valid  = 1'b0;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) begin @(posedge clk); #1; end
   endtask

   // Monitor: compares every expectation due at this cycle.
   item_t it;
   string nm;
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
         it = sb_q.pop_front();
         nm = nm_q.pop_front();
         n_cmp++;
         if (it.at != cyc || (((led ^ it.le) & it.lm) !== 3'b000) ||
             (((wrap ^ it.we) & it.wm) !== 3'b000) || (cfg_ready !== it.re)) begin
            n_err++;
            $display("FAIL %s cyc=%0d(due %0d): led=%b wrap=%b rdy=%b, required led=%b(mask %b) wrap=%b(mask %b) rdy=%b",
                     nm, cyc, it.at, led, wrap, cfg_ready, it.le, it.lm, it.we, it.wm, it.re);
         end
      end
      if (done && (sb_q.size() == 0 || cyc > done_cyc)) begin
         if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL timeout: %0d expectations never checked, required 0", sb_q.size());
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
         $finish;
      end
   end

   initial begin
      int k;
      logic l0k;
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0;
      cfg_period = '0; cfg_duty = '0;

      // Held in reset: everything low, port closed.
      repeat (3) begin @(posedge clk); #1; pushf(cyc, 3'b000, 3'b000, 1'b0, "reset_hold"); end
      @(posedge clk); #1;
      rst_n = 1'b1; pr = cyc;

      // Idle after reset: all off, no wraps.
      k = cyc;
      for (int t = k + 1; t <= k + 100; t++) pushf(t, 3'b000, 3'b000, 1'b1, "idle");
      wait_to(k + 100);

      // ch0 BLINK period 3: led rises k+5, toggles every 4, wrap every 4.
      k = cyc + 1; k0 = k;
      for (int t = k; t <= k + 40; t++)
         pushf(t, {2'b00, b0l(t)}, {2'b00, b0w(t)}, 1'b1, "blink_p3");
      wr(0, LED_BLINK, 3, 0);
      wait_to(k + 40);

      // ch1 PWM duty 64: 64 high of every 256.
      k = cyc + 1;
      for (int t = k; t <= k + 300; t++)
         pushf(t, {1'b0, (t > k) ? p1(t, 64) : 1'b0, b0l(t)}, {2'b00, b0w(t)}, 1'b1, "pwm64");
      wr(1, LED_PWM, 100000, 64);
      wait_to(k + 300);

      // ch1 PWM duty 0: constant low from the next edge.
      k = cyc + 1;
      for (int t = k; t <= k + 260; t++)
         pushf(t, {1'b0, (t == k) ? p1(t, 64) : 1'b0, b0l(t)}, {2'b00, b0w(t)}, 1'b1, "pwm0");
      wr(1, LED_PWM, 100000, 0);
      wait_to(k + 260);

      // ch2 ON then OFF on consecutive cycles: one-cycle high.
      k = cyc + 1;
      for (int t = k; t <= k + 10; t++)
         pushf(t, {(t == k + 1), 1'b0, b0l(t)}, {2'b00, b0w(t)}, 1'b1, "on_off");
      wr(2, LED_ON, 100000, 0);
      wr(2, LED_OFF, 100000, 0);
      wait_to(k + 10);

      // Out-of-range channel: accepted, nothing changes.
      k = cyc + 1;
      for (int t = k; t <= k + 20; t++)
         pushf(t, {2'b00, b0l(t)}, {2'b00, b0w(t)}, 1'b1, "bad_ch");
      wr(3, LED_ON, 0, 255);
      wait_to(k + 20);

      // ch2 BLINK period 0: toggles and wraps every cycle.
      k = cyc + 1; k2 = k;
      for (int t = k; t <= k + 20; t++)
         pushf(t, {b2l(t), 1'b0, b0l(t)}, {b2w(t), 1'b0, b0w(t)}, 1'b1, "blink_p0");
      wr(2, LED_BLINK, 0, 0);
      wait_to(k + 20);

      // Rewrite ch0 on the edge it would wrap: write wins, no wrap pulse.
      while (((cyc + 1 - k0) % 4) != 0) begin @(posedge clk); #1; end
      k = cyc + 1; l0k = b0l(k); k0 = k;
      pushf(k, {b2l(k), 1'b0, l0k}, {b2w(k), 2'b00}, 1'b1, "wr_beats_wrap");
      for (int t = k + 1; t <= k + 20; t++)
         pushf(t, {b2l(t), 1'b0, b0l(t)}, {b2w(t), 1'b0, b0w(t)}, 1'b1, "reblink");
      wr(0, LED_BLINK, 3, 0);
      wait_to(k + 20);

      // ch1 ON so at least one LED is surely high, then async reset mid-cycle.
      k = cyc + 1;
      for (int t = k; t <= k + 4; t++)
         pushf(t, {b2l(t), (t > k), b0l(t)}, {b2w(t), 1'b0, b0w(t)}, 1'b1, "ch1_on");
      wr(1, LED_ON, 100000, 0);
      wait_to(k + 5);
      pushf(cyc, 3'b000, 3'b000, 1'b0, "async_rst");
      #3 rst_n = 1'b0;
      @(posedge clk); #1;
      pushf(cyc, 3'b000, 3'b000, 1'b0, "rst_hold2");
      @(posedge clk); #1;
      rst_n = 1'b1; pr = cyc;

      // After release: all channels back to OFF.
      k = cyc;
      for (int t = k + 1; t <= k + 20; t++) pushf(t, 3'b000, 3'b000, 1'b1, "post_rst");
      wait_to(k + 20);

      // PWM again: frame counter restarted from 0 by the reset.
      k = cyc + 1;
      for (int t = k; t <= k + 300; t++)
         pushf(t, {1'b0, (t > k) ? p1(t, 64) : 1'b0, 1'b0}, 3'b000, 1'b1, "pwm_after_rst");
      wr(1, LED_PWM, 100000, 64);
      wait_to(k + 300);

      done_cyc = cyc + 20;
      done = 1'b1;
   end

endmodule : tb_led_pattern_gen
